bus_demux_n: RTL and testbench
==============================

# bus_demux_n

Parametrised one-master-to-N-slave request/acknowledge demultiplexer for the on-chip bus. Decodes the upper address bits of a master request to select one of `N_SLAVES` slave ports and registers the transfer. Holds the request to that slave until it acknowledges, then returns read data and an error flag to the master. Adds decode-error and slave-timeout responses, so a bad address or dead slave cannot hang the master. This replaces the fixed two-slave, single-address-bit master mux.

## Interface
Parameters:
- `N_SLAVES`, 4: number of slave ports, 2..16.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `SEL_W`, 2: number of top address bits used as the slave index. Requires 2**SEL_W >= N_SLAVES.
- `TIMEOUT`, 16: maximum cycles spent waiting for a slave ack. 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m_req`  in  1  master request; held until `m_ack`.
- `m_addr`  in  AW  master address.
- `m_cmd`  in  1  1 = write, 0 = read.
- `m_wdata`  in  DW  master write data.
- `m_ack`  out  1  one-cycle response pulse to the master.
- `m_rdata`  out  DW  read data, valid when `m_ack` = 1.
- `m_err`  out  1  error flag, valid when `m_ack` = 1.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `s_req`  out  N_SLAVES  one-hot request, one bit per slave.
- `s_addr`  out  AW  latched address, broadcast to all slaves.
- `s_cmd`  out  1  latched command, broadcast.
- `s_wdata`  out  DW  latched write data, broadcast.
- `s_ack`  in  N_SLAVES  per-slave acknowledge pulse.
- `s_rdata`  in  N_SLAVES*DW  per-slave read data; slave i occupies bits [i*DW +: DW].

## Operation
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- Slave index: idx = m_addr[AW-1 -: SEL_W].
- IDLE:
  - If `m_req` = 1 and idx < N_SLAVES: latch addr, cmd, wdata and idx; clear the wait counter; go to WAIT.
  - If `m_req` = 1 and idx >= N_SLAVES: load m_rdata = 0, m_err = 1; go to RESP. No slave request is issued.
  - If `m_req` = 0: stay in IDLE.
- WAIT:
  - s_req[idx] = 1; all other `s_req` bits are 0. `s_addr`, `s_cmd` and `s_wdata` hold the latched values.
  - If s_ack[idx] = 1: capture s_rdata slice idx into m_rdata, set m_err = 0, go to RESP.
  - Otherwise, if TIMEOUT != 0 and the counter = TIMEOUT-1: set m_rdata = 0, m_err = 1, go to RESP.
  - Otherwise: increment the counter and stay in WAIT.
- Ack takes priority over timeout when both occur in the same cycle.
- Acks from unselected slaves are ignored.
- RESP: m_ack = 1 for exactly one cycle, all `s_req` = 0, then go to IDLE.
- `m_rdata` and `m_err` hold their values until the next response is loaded.
- `m_rdata` is loaded on writes as well; it is don't-care to the master.
- `s_addr`, `s_cmd` and `s_wdata` hold their last latched values outside WAIT.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and the wait counter to 0.
- Reset takes effect immediately (asynchronous), including in the middle of WAIT or RESP. `s_req` drops without waiting for any ack.
- Normal latency:
  - `m_req` sampled at edge 0; `s_req` rises in the cycle after edge 0.
  - Slave acks in its k-th WAIT cycle (k >= 1).
  - `m_ack` is high in the cycle after that ack.
  - `m_req` to `m_ack` is k+1 edges; the minimum is 2 edges.
- Decode-error latency: `m_ack` is high in the cycle after the sampling edge, i.e. 1 edge.
- Timeout: at most TIMEOUT WAIT cycles, then one RESP cycle.
- A slave ack arriving after a timeout, in RESP or IDLE, is ignored.
- Master contract:
  - Hold `m_req`, `m_addr`, `m_cmd` and `m_wdata` stable until the `m_ack` cycle.
  - The master may deassert `m_req`, or present a new request, at the edge that ends the `m_ack` cycle.
  - IDLE samples the next request no earlier than one edge after that. There are no back-to-back double issues.
- Slave contract:
  - `s_ack` is a single-cycle pulse.
  - `s_rdata` must be valid in the same cycle as `s_ack`.
- `busy` = 1 in WAIT and RESP.

## Test plan
- **Write to slave 1, immediate ack.**
  - Stimulus: N_SLAVES=4; m_addr=0x4000_0010, cmd=1, wdata=0xA5A5_A5A5; s_ack[1]=1 in the first WAIT cycle.
  - Required: s_req=4'b0010; s_addr=0x4000_0010; s_wdata=0xA5A5_A5A5; one m_ack pulse 2 edges after the request with m_err=0.
- **Read from slave 2, delayed ack.**
  - Stimulus: m_addr=0x8000_0000, cmd=0; s_ack[2] in the 3rd WAIT cycle with slice 2 = 0x1234_5678. s_ack[0] pulses during WAIT.
  - Required: m_ack 4 edges after the request with m_rdata=0x1234_5678, m_err=0. The s_ack[0] pulse has no effect.
- **Decode error.**
  - Stimulus: N_SLAVES=3, m_addr=0xC000_0000.
  - Required: s_req stays 0; m_ack 1 edge after the request with m_err=1, m_rdata=0.
- **Timeout.**
  - Stimulus: TIMEOUT=4; the slave never acks.
  - Required: exactly 4 WAIT cycles with s_req high, then m_ack with m_err=1, m_rdata=0. A late s_ack afterwards is ignored.
- **Ack on the final timeout cycle.**
  - Stimulus: TIMEOUT=4; slave acks in the 4th WAIT cycle with data 0xCAFE_0001.
  - Required: m_err=0, m_rdata=0xCAFE_0001.
- **Reset mid-WAIT.**
  - Stimulus: assert rst in the 2nd WAIT cycle.
  - Required: all outputs 0 immediately; after rst is released, a new request completes normally.

Source files
------------

// File: rtl/bus_demux_n.sv
// bus_demux_n: one master to N slaves request/acknowledge demultiplexer.
// The top address bits select a slave. The transfer is latched and held on
// that slave until it acks. Read data or an error then returns to the master.
// A decode error or a slave timeout produces an m_err response.
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   m_req/m_addr/m_cmd/m_wdata        master request, held until m_ack
//   m_ack/m_rdata/m_err               one-cycle master response
//   busy                              FSM is not in IDLE
//   s_req                             one-hot slave request
//   s_addr/s_cmd/s_wdata              latched transfer, broadcast to all slaves
//   s_ack/s_rdata                     per-slave ack and read data (slice i = slave i)
module bus_demux_n #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req,
  input  logic [AW-1:0]          m_addr,
  input  logic                   m_cmd,
  input  logic [DW-1:0]          m_wdata,
  output logic                   m_ack,
  output logic [DW-1:0]          m_rdata,
  output logic                   m_err,
  output logic                   busy,
  output logic [N_SLAVES-1:0]    s_req,
  output logic [AW-1:0]          s_addr,
  output logic                   s_cmd,
  output logic [DW-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]    s_ack,
  input  logic [N_SLAVES*DW-1:0] s_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [SEL_W:0] IDX_LIM = (SEL_W+1)'(N_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic                r_cmd, w_cmd_nxt;
  logic [DW-1:0]       r_wdata, w_wdata_nxt;
  logic [DW-1:0]       r_rdata, w_rdata_nxt;
  logic                r_err, w_err_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_busy, w_busy_nxt;
  logic [N_SLAVES-1:0] r_sreq, w_sreq_nxt;

  logic [SEL_W-1:0]    w_idx;
  logic                w_idx_ok;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_sel_ack;
  logic [DW-1:0]       w_sel_rdata;

  assign w_idx    = m_addr[AW-1 -: SEL_W];
  assign w_idx_ok = ({1'b0, w_idx} < IDX_LIM);

  // Decode the incoming index to one-hot and select the latched slave's ack/data.
  always_comb begin
    w_onehot    = '0;
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      w_onehot[i] = (w_idx == SEL_W'(i));
      if (r_idx == SEL_W'(i)) begin
        w_sel_ack   = s_ack[i];
        w_sel_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  // State register plus every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_cmd   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_sreq  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_cmd   <= w_cmd_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_sreq  <= w_sreq_nxt;
    end
  end

  // Next state and next register values. s_req and m_ack are computed one
  // cycle ahead so they appear exactly in the WAIT and RESP cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_cmd_nxt   = r_cmd;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_ack_nxt   = 1'b0;
    w_sreq_nxt  = '0;

    case (r_state)
      ST_IDLE: begin
        if (m_req) begin
          if (w_idx_ok) begin
            w_idx_nxt   = w_idx;
            w_cnt_nxt   = '0;
            w_addr_nxt  = m_addr;
            w_cmd_nxt   = m_cmd;
            w_wdata_nxt = m_wdata;
            w_sreq_nxt  = w_onehot;
            w_state_nxt = ST_WAIT;
          end else begin
            // Unmapped slave index: answer at once with an error.
            w_rdata_nxt = '0;
            w_err_nxt   = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (w_sel_ack) begin
          w_rdata_nxt = w_sel_rdata;
          w_err_nxt   = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_sreq_nxt  = r_sreq;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign m_ack   = r_ack;
  assign m_rdata = r_rdata;
  assign m_err   = r_err;
  assign busy    = r_busy;
  assign s_req   = r_sreq;
  assign s_addr  = r_addr;
  assign s_cmd   = r_cmd;
  assign s_wdata = r_wdata;

endmodule

// File: tb/tb_bus_demux_n.sv
// tb_bus_demux_n: directed, table-driven bench for bus_demux_n.
// u_dut: 4 slaves, TIMEOUT=4. u_dut3: 3 slaves, used for decode errors.
module tb_bus_demux_n;

  logic         clk;
  logic         rst;

  logic         m_req;
  logic [31:0]  m_addr;
  logic         m_cmd;
  logic [31:0]  m_wdata;
  logic         m_ack;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic         busy;
  logic [3:0]   s_req;
  logic [31:0]  s_addr;
  logic         s_cmd;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ack;
  logic [127:0] s_rdata;

  logic         m3_req;
  logic [31:0]  m3_addr;
  logic         m3_cmd;
  logic [31:0]  m3_wdata;
  logic         m3_ack;
  logic [31:0]  m3_rdata;
  logic         m3_err;
  logic         busy3;
  logic [2:0]   s3_req;
  logic [31:0]  s3_addr;
  logic         s3_cmd;
  logic [31:0]  s3_wdata;
  logic [2:0]   s3_ack;
  logic [95:0]  s3_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] GARB = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};

  bus_demux_n #(.N_SLAVES(4), .AW(32), .DW(32), .SEL_W(2), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err), .busy(busy),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  bus_demux_n #(.N_SLAVES(3), .AW(32), .DW(32), .SEL_W(2), .TIMEOUT(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .m_req(m3_req), .m_addr(m3_addr), .m_cmd(m3_cmd), .m_wdata(m3_wdata),
    .m_ack(m3_ack), .m_rdata(m3_rdata), .m_err(m3_err), .busy(busy3),
    .s_req(s3_req), .s_addr(s3_addr), .s_cmd(s3_cmd), .s_wdata(s3_wdata),
    .s_ack(s3_ack), .s_rdata(s3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    int          ack_cyc;    // WAIT cycle of the selected ack, 0 = never
    logic [3:0]  ack_mask;
    int          noise_cyc;  // WAIT cycle of an unselected ack, 0 = none
    logic [3:0]  noise_mask;
    logic [31:0] slv_data;
    logic [3:0]  exp_sreq;
    int          exp_lat;    // edges from request to m_ack
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one edge, sample 1ns later; slave ack pulses end by default.
  task automatic step();
    @(posedge clk);
    #1;
    s_ack   = '0;
    s_rdata = GARB;
    s3_ack  = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  done;
    m_req   = 1'b1;
    m_addr  = v.addr;
    m_cmd   = v.cmd;
    m_wdata = v.wdata;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      step();
      cyc++;
      if (m_ack) begin
        done = 1'b1;
        chk({v.name, "/lat"}, 32'(cyc), 32'(v.exp_lat));
        chk({v.name, "/err"}, 32'(m_err), 32'(v.exp_err));
        if (!v.cmd || v.exp_err) chk({v.name, "/rdata"}, m_rdata, v.exp_rdata);
        chk({v.name, "/sreq_resp"}, 32'(s_req), 32'h0);
      end else if (cyc > 12) begin
        done = 1'b1;
        chk({v.name, "/no_ack_in_budget"}, 32'(cyc), 32'(v.exp_lat));
      end else begin
        chk($sformatf("%s/sreq%0d", v.name, cyc), 32'(s_req), 32'(v.exp_sreq));
        chk($sformatf("%s/busy%0d", v.name, cyc), 32'(busy), 32'h1);
        if (cyc == 1) begin
          chk({v.name, "/s_addr"}, s_addr, v.addr);
          chk({v.name, "/s_wdata"}, s_wdata, v.wdata);
          chk({v.name, "/s_cmd"}, 32'(s_cmd), 32'(v.cmd));
        end
        if (cyc == v.ack_cyc) begin
          s_ack = s_ack | v.ack_mask;
          for (int j = 0; j < 4; j++)
            if (v.ack_mask[j]) s_rdata[j*32 +: 32] = v.slv_data;
        end
        if (cyc == v.noise_cyc) s_ack = s_ack | v.noise_mask;
      end
    end
    m_req = 1'b0;
    step();
    chk({v.name, "/ack_drop"}, 32'(m_ack), 32'h0);
    chk({v.name, "/idle"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "/m_ack"},   32'(m_ack), 32'h0);
    chk({nm, "/m_rdata"}, m_rdata, 32'h0);
    chk({nm, "/m_err"},   32'(m_err), 32'h0);
    chk({nm, "/busy"},    32'(busy), 32'h0);
    chk({nm, "/s_req"},   32'(s_req), 32'h0);
    chk({nm, "/s_addr"},  s_addr, 32'h0);
    chk({nm, "/s_cmd"},   32'(s_cmd), 32'h0);
    chk({nm, "/s_wdata"}, s_wdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr_s1_imm",  32'h4000_0010, 1'b1, 32'hA5A5_A5A5, 1, 4'b0010, 0, 4'b0000,
                32'h0000_0000, 4'b0010, 2, 1'b0, 32'h0000_0000};
    vecs[1] = '{"rd_s2_dly",  32'h8000_0000, 1'b0, 32'h0000_0000, 3, 4'b0100, 1, 4'b0001,
                32'h1234_5678, 4'b0100, 4, 1'b0, 32'h1234_5678};
    vecs[2] = '{"timeout_s3", 32'hC000_0004, 1'b0, 32'h0000_0000, 0, 4'b0000, 2, 4'b0001,
                32'h0000_0000, 4'b1000, 5, 1'b1, 32'h0000_0000};
    vecs[3] = '{"ack_last",   32'h0000_0020, 1'b0, 32'h0000_0000, 4, 4'b0001, 0, 4'b0000,
                32'hCAFE_0001, 4'b0001, 5, 1'b0, 32'hCAFE_0001};
    vecs[4] = '{"rd_s3_noise",32'hC000_0100, 1'b0, 32'h0000_0000, 1, 4'b1000, 1, 4'b0100,
                32'h0BAD_F00D, 4'b1000, 2, 1'b0, 32'h0BAD_F00D};

    rst = 1'b1;
    m_req = 1'b0; m_addr = '0; m_cmd = 1'b0; m_wdata = '0;
    s_ack = '0; s_rdata = GARB;
    m3_req = 1'b0; m3_addr = '0; m3_cmd = 1'b0; m3_wdata = '0;
    s3_ack = '0; s3_rdata = GARB[95:0];
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Timeout followed by late acks in RESP and IDLE.
    m_req = 1'b1; m_addr = 32'h4000_0000; m_cmd = 1'b0; m_wdata = '0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("late/sreq%0d", c), 32'(s_req), 32'h2);
    end
    step();
    chk("late/to_ack", 32'(m_ack), 32'h1);
    chk("late/to_err", 32'(m_err), 32'h1);
    chk("late/to_rdata", m_rdata, 32'h0);
    m_req = 1'b0;
    s_ack = 4'b0010;
    s_rdata[63:32] = 32'h1111_2222;
    step();
    chk("late/resp_ack_ignored", 32'(m_ack), 32'h0);
    chk("late/err_held", 32'(m_err), 32'h1);
    chk("late/rdata_held", m_rdata, 32'h0);
    s_ack = 4'b0010;
    s_rdata[63:32] = 32'h1111_2222;
    step();
    chk("late/idle_busy", 32'(busy), 32'h0);
    chk("late/idle_ack", 32'(m_ack), 32'h0);
    chk("late/idle_rdata", m_rdata, 32'h0);

    // Reset asserted in the second WAIT cycle.
    m_req = 1'b1; m_addr = 32'h8000_0040; m_cmd = 1'b1; m_wdata = 32'h7777_0000;
    step();
    step();
    chk("rstwait/sreq_before", 32'(s_req), 32'h4);
    #1;
    rst = 1'b1;
    m_req = 1'b0;
    #1;
    chk_all_zero("rstwait");
    #3;
    rst = 1'b0;
    step();
    chk_all_zero("rstwait_after");
    run_vec(vecs[0]);

    // Three-slave instance: a good read, then a decode error.
    m3_req = 1'b1; m3_addr = 32'h4000_0000; m3_cmd = 1'b0;
    step();
    chk("d3/sreq", 32'(s3_req), 32'h2);
    s3_ack = 3'b010;
    s3_rdata[63:32] = 32'h55AA_55AA;
    step();
    s3_rdata = GARB[95:0];
    chk("d3/ack", 32'(m3_ack), 32'h1);
    chk("d3/rdata", m3_rdata, 32'h55AA_55AA);
    chk("d3/err", 32'(m3_err), 32'h0);
    m3_req = 1'b0;
    step();
    m3_req = 1'b1; m3_addr = 32'hC000_0000;
    step();
    chk("dec/ack", 32'(m3_ack), 32'h1);
    chk("dec/err", 32'(m3_err), 32'h1);
    chk("dec/rdata", m3_rdata, 32'h0);
    chk("dec/sreq", 32'(s3_req), 32'h0);
    chk("dec/busy", 32'(busy3), 32'h1);
    m3_req = 1'b0;
    step();
    chk("dec/ack_drop", 32'(m3_ack), 32'h0);
    chk("dec/idle", 32'(busy3), 32'h0);
    chk("dec/sreq_idle", 32'(s3_req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
